// File: rtl/meikyuu_pkg.sv
// -----------------------------------------------------------------------------
// meikyuu_pkg
// Shared constants and types for the maze game datapath.
//   - Tile codes returned by the maze tile ROM.
//   - VGA active-area geometry and the map origin on screen.
//   - Player spawn position (shared with the player movement block).
//   - State enum of the collision gate.
//   - Small helpers that classify tile codes.
// -----------------------------------------------------------------------------
package meikyuu_pkg;

    // Tile codes
    localparam logic [1:0] TILE_FLOOR = 2'b00;
    localparam logic [1:0] TILE_WALL  = 2'b01;
    localparam logic [1:0] TILE_GOAL  = 2'b10;
    localparam logic [1:0] TILE_RSVD  = 2'b11;

    // VGA geometry
    localparam int VGA_W    = 640;
    localparam int VGA_H    = 480;
    localparam int X_ORIGIN = 128;
    localparam int Y_ORIGIN = 35;

    // Player spawn point
    localparam int SPAWN_X  = 455;
    localparam int SPAWN_Y  = 266;

    // Collision gate sequencing
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_LAST = 3'd5
    } gate_state_e;

    // Reserved tiles are treated as solid, same as walls.
    function automatic logic tile_is_solid(input logic [1:0] tile);
        return (tile == TILE_WALL) || (tile == TILE_RSVD);
    endfunction

    function automatic logic tile_is_goal(input logic [1:0] tile);
        return (tile == TILE_GOAL);
    endfunction

endpackage

// File: rtl/maze_tile_addr.sv
// -----------------------------------------------------------------------------
// maze_tile_addr
// Combinational translation of a candidate sprite position plus a corner index
// into a maze tile ROM address (row*MAP_W + col).
// Corner index bit 0 selects the far x edge, bit 1 selects the far y edge.
// Screen coordinates are wrapped into the 640x480 active area with a single
// correction step, so a sprite straddling the screen edge addresses tiles on
// both sides of the map (wrap-around tunnels).
// Ports:
//   cand_x   in  10  candidate x, VGA coordinates
//   cand_y   in  10  candidate y, VGA coordinates
//   corner   in   2  corner index: 0=(0,0) 1=(S,0) 2=(0,S) 3=(S,S)
//   map_addr out 11  tile ROM address
// -----------------------------------------------------------------------------
module maze_tile_addr
    import meikyuu_pkg::*;
#(
    parameter int MAP_W       = 40,
    parameter int TILE_SHIFT  = 4,
    parameter int SPRITE_SIZE = 16,
    parameter int X_ORG       = X_ORIGIN,
    parameter int Y_ORG       = Y_ORIGIN
) (
    input  logic [9:0]  cand_x,
    input  logic [9:0]  cand_y,
    input  logic [1:0]  corner,
    output logic [10:0] map_addr
);

    localparam logic signed [10:0] X_OFF   = 11'(X_ORG);
    localparam logic signed [10:0] Y_OFF   = 11'(Y_ORG);
    localparam logic signed [10:0] FAR_OFF = 11'(SPRITE_SIZE - 1);
    localparam logic signed [10:0] WRAP_X  = 11'(VGA_W);
    localparam logic signed [10:0] WRAP_Y  = 11'(VGA_H);
    localparam logic [10:0]        MAP_W_L = 11'(MAP_W);

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic signed [10:0] rx_raw_s;
    logic signed [10:0] ry_raw_s;
    logic signed [10:0] rx_s;
    logic signed [10:0] ry_s;
    logic [10:0]        col_s;
    logic [10:0]        row_s;

    // Map-relative pixel of the selected corner, wrapped into the active area.
    always_comb begin
        dx_s     = corner[0] ? FAR_OFF : 11'sd0;
        dy_s     = corner[1] ? FAR_OFF : 11'sd0;
        rx_raw_s = $signed({1'b0, cand_x}) - X_OFF + dx_s;
        ry_raw_s = $signed({1'b0, cand_y}) - Y_OFF + dy_s;

        if (rx_raw_s >= WRAP_X) begin
            rx_s = rx_raw_s - WRAP_X;
        end else if (rx_raw_s < 11'sd0) begin
            rx_s = rx_raw_s + WRAP_X;
        end else begin
            rx_s = rx_raw_s;
        end

        if (ry_raw_s >= WRAP_Y) begin
            ry_s = ry_raw_s - WRAP_Y;
        end else if (ry_raw_s < 11'sd0) begin
            ry_s = ry_raw_s + WRAP_Y;
        end else begin
            ry_s = ry_raw_s;
        end
    end

    // Tile coordinates and linear ROM address.
    always_comb begin
        col_s    = 11'(rx_s) >> TILE_SHIFT;
        row_s    = 11'(ry_s) >> TILE_SHIFT;
        map_addr = row_s * MAP_W_L + col_s;
    end

endmodule

// File: rtl/maze_collision_gate.sv
// -----------------------------------------------------------------------------
// maze_collision_gate
// Closes the player position loop: latches each proposed sprite position,
// reads the four sprite-corner tiles from the external maze tile ROM (one-cycle
// read latency) and either commits the move or rejects it.
// Optional feature macro: MEIKYUU_GOAL_DETECT_EN
//   defined   - a committed move touching a goal tile sets goal_reached (sticky)
//   undefined - goal tiles are plain floor, goal_reached is tied to 0
// Ports:
//   CLOCK_25     in   1  25 MHz pixel clock
//   reset        in   1  asynchronous, active-high
//   prop_x       in  10  proposed x (VGA)
//   prop_y       in  10  proposed y (VGA)
//   map_addr     out 11  tile ROM address (row*MAP_W + col)
//   map_tile     in   2  tile ROM data, valid one cycle after map_addr
//   commit_x     out 10  committed x
//   commit_y     out 10  committed y
//   busy         out  1  check in flight
//   blocked      out  1  one-cycle pulse on a rejected move
//   goal_reached out  1  sticky goal flag
// -----------------------------------------------------------------------------
module maze_collision_gate
    import meikyuu_pkg::*;
#(
    parameter int MAP_W       = 40,
    parameter int MAP_H       = 30,
    parameter int TILE_SHIFT  = 4,
    parameter int SPRITE_SIZE = 16,
    parameter int X_ORG       = X_ORIGIN,
    parameter int Y_ORG       = Y_ORIGIN,
    parameter int SPAWN_XP    = SPAWN_X,
    parameter int SPAWN_YP    = SPAWN_Y
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    input  logic [9:0]  prop_x,
    input  logic [9:0]  prop_y,
    output logic [10:0] map_addr,
    input  logic [1:0]  map_tile,
    output logic [9:0]  commit_x,
    output logic [9:0]  commit_y,
    output logic        busy,
    output logic        blocked,
    output logic        goal_reached
);

    localparam logic [9:0] SPAWN_X_L = 10'(SPAWN_XP);
    localparam logic [9:0] SPAWN_Y_L = 10'(SPAWN_YP);

    gate_state_e state_q, state_d;
    logic [9:0]  cand_x_q, cand_x_d;
    logic [9:0]  cand_y_q, cand_y_d;
    logic [9:0]  commit_x_q, commit_x_d;
    logic [9:0]  commit_y_q, commit_y_d;
    logic        wall_seen_q, wall_seen_d;
    logic        blocked_q, blocked_d;
    logic [1:0]  corner_s;
    logic [10:0] corner_addr_s;
    logic        solid_final_s;
`ifdef MEIKYUU_GOAL_DETECT_EN
    logic        goal_seen_q, goal_seen_d;
    logic        goal_reached_q, goal_reached_d;
    logic        goal_final_s;
`endif

    // Corner presented on the ROM address bus in each read state; LAST keeps
    // corner 3 so the address stays stable while its data returns.
    always_comb begin
        case (state_q)
            ST_RD0:  corner_s = 2'd0;
            ST_RD1:  corner_s = 2'd1;
            ST_RD2:  corner_s = 2'd2;
            ST_RD3:  corner_s = 2'd3;
            ST_LAST: corner_s = 2'd3;
            default: corner_s = 2'd0;
        endcase
    end

    maze_tile_addr #(
        .MAP_W       (MAP_W),
        .TILE_SHIFT  (TILE_SHIFT),
        .SPRITE_SIZE (SPRITE_SIZE),
        .X_ORG       (X_ORG),
        .Y_ORG       (Y_ORG)
    ) u_tile_addr (
        .cand_x   (cand_x_q),
        .cand_y   (cand_y_q),
        .corner   (corner_s),
        .map_addr (corner_addr_s)
    );

    // Address bus is parked at 0 while idle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            map_addr = 11'd0;
        end else begin
            map_addr = corner_addr_s;
        end
    end

    // The last corner's tile is still on map_tile when the decision is made,
    // so it is folded in directly rather than through the capture flags.
    always_comb begin
        solid_final_s = wall_seen_q | tile_is_solid(map_tile);
`ifdef MEIKYUU_GOAL_DETECT_EN
        goal_final_s  = goal_seen_q | tile_is_goal(map_tile);
`endif
    end

    // Next-state logic: sequence the four corner reads and decide at LAST.
    always_comb begin
        state_d     = state_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        commit_x_d  = commit_x_q;
        commit_y_d  = commit_y_q;
        wall_seen_d = wall_seen_q;
        blocked_d   = 1'b0;
`ifdef MEIKYUU_GOAL_DETECT_EN
        goal_seen_d    = goal_seen_q;
        goal_reached_d = goal_reached_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((prop_x != commit_x_q) || (prop_y != commit_y_q)) begin
                    cand_x_d    = prop_x;
                    cand_y_d    = prop_y;
                    wall_seen_d = 1'b0;
`ifdef MEIKYUU_GOAL_DETECT_EN
                    goal_seen_d = 1'b0;
`endif
                    state_d     = ST_RD0;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_RD0: begin
                state_d = ST_RD1;
            end
            // RD1..RD3 each capture the tile addressed one state earlier.
            ST_RD1, ST_RD2, ST_RD3: begin
                wall_seen_d = wall_seen_q | tile_is_solid(map_tile);
`ifdef MEIKYUU_GOAL_DETECT_EN
                goal_seen_d = goal_seen_q | tile_is_goal(map_tile);
`endif
                if (state_q == ST_RD1) begin
                    state_d = ST_RD2;
                end else if (state_q == ST_RD2) begin
                    state_d = ST_RD3;
                end else begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                if (!solid_final_s) begin
                    commit_x_d = cand_x_q;
                    commit_y_d = cand_y_q;
`ifdef MEIKYUU_GOAL_DETECT_EN
                    if (goal_final_s) begin
                        goal_reached_d = 1'b1;
                    end else begin
                        goal_reached_d = goal_reached_q;
                    end
`endif
                end else begin
                    blocked_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cand_x_q    <= 10'd0;
            cand_y_q    <= 10'd0;
            commit_x_q  <= SPAWN_X_L;
            commit_y_q  <= SPAWN_Y_L;
            wall_seen_q <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            commit_x_q  <= commit_x_d;
            commit_y_q  <= commit_y_d;
            wall_seen_q <= wall_seen_d;
            blocked_q   <= blocked_d;
        end
    end

`ifdef MEIKYUU_GOAL_DETECT_EN
    // Goal tracking registers.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            goal_seen_q    <= 1'b0;
            goal_reached_q <= 1'b0;
        end else begin
            goal_seen_q    <= goal_seen_d;
            goal_reached_q <= goal_reached_d;
        end
    end

    assign goal_reached = goal_reached_q;
`else
    assign goal_reached = 1'b0;
`endif

    assign commit_x = commit_x_q;
    assign commit_y = commit_y_q;
    assign busy     = (state_q != ST_IDLE);
    assign blocked  = blocked_q;

endmodule

// File: tb/tb_maze_collision_gate.sv
// -----------------------------------------------------------------------------
// tb_maze_collision_gate
// Directed self-checking bench for maze_collision_gate. A registered tile ROM
// model returns floor everywhere except one programmable special address.
// -----------------------------------------------------------------------------
module tb_maze_collision_gate;

    logic        clk;
    logic        reset;
    logic [9:0]  prop_x;
    logic [9:0]  prop_y;
    logic [10:0] map_addr;
    logic [1:0]  map_tile;
    logic [9:0]  commit_x;
    logic [9:0]  commit_y;
    logic        busy;
    logic        blocked;
    logic        goal_reached;

    int          n_tests;
    int          n_fail;
    int          special_addr;
    logic [1:0]  special_code;

    maze_collision_gate dut (
        .CLOCK_25     (clk),
        .reset        (reset),
        .prop_x       (prop_x),
        .prop_y       (prop_y),
        .map_addr     (map_addr),
        .map_tile     (map_tile),
        .commit_x     (commit_x),
        .commit_y     (commit_y),
        .busy         (busy),
        .blocked      (blocked),
        .goal_reached (goal_reached)
    );

    // 25 MHz clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Tile ROM model with one-cycle read latency
    always @(posedge clk) begin
        if (int'(map_addr) == special_addr) begin
            map_tile <= special_code;
        end else begin
            map_tile <= 2'b00;
        end
    end

    // Hard time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        prop_x = 10'd455;
        prop_y = 10'd266;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
    endtask

    // Drive a proposal, follow the four corner addresses, then check the
    // decision. The player model returns prop to the expected commit before E5.
    task automatic run_move(input string tag,
                            input logic [9:0] px, input logic [9:0] py,
                            input logic [10:0] a0, input logic [10:0] a1,
                            input logic [10:0] a2, input logic [10:0] a3,
                            input logic [9:0] ex, input logic [9:0] ey,
                            input logic eb);
        prop_x = px;
        prop_y = py;
        tick();
        check_eq({tag, "_addr0"}, 32'(map_addr), 32'(a0));
        check_eq({tag, "_busy_rd0"}, 32'(busy), 32'd1);
        tick();
        check_eq({tag, "_addr1"}, 32'(map_addr), 32'(a1));
        tick();
        check_eq({tag, "_addr2"}, 32'(map_addr), 32'(a2));
        tick();
        check_eq({tag, "_addr3"}, 32'(map_addr), 32'(a3));
        tick();
        check_eq({tag, "_addr_last"}, 32'(map_addr), 32'(a3));
        check_eq({tag, "_busy_last"}, 32'(busy), 32'd1);
        prop_x = ex;
        prop_y = ey;
        tick();
        check_eq({tag, "_commit_x"}, 32'(commit_x), 32'(ex));
        check_eq({tag, "_commit_y"}, 32'(commit_y), 32'(ey));
        check_eq({tag, "_blocked"}, 32'(blocked), 32'(eb));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check_eq({tag, "_blocked_clr"}, 32'(blocked), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        special_addr = -1;
        special_code = 2'b00;
        reset        = 1'b0;
        prop_x       = 10'd455;
        prop_y       = 10'd266;

        // Asynchronous reset before any clock edge
        #5;
        reset = 1'b1;
        #1;
        check_eq("rst_commit_x", 32'(commit_x), 32'd455);
        check_eq("rst_commit_y", 32'(commit_y), 32'd266);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_blocked", 32'(blocked), 32'd0);
        check_eq("rst_map_addr", 32'(map_addr), 32'd0);
        check_eq("rst_goal", 32'(goal_reached), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Floor move in x
        run_move("floor_x", 10'd456, 10'd266, 11'd580, 11'd581, 11'd620, 11'd621,
                 10'd456, 10'd266, 1'b0);

        // Floor move in y: rows 16/17, cols 20/21
        do_reset();
        run_move("floor_y", 10'd455, 10'd300, 11'd660, 11'd661, 11'd700, 11'd701,
                 10'd455, 10'd300, 1'b0);

        // Wall on the last corner, seen straight off the ROM bus
        do_reset();
        special_addr = 621;
        special_code = 2'b01;
        run_move("wall_c3", 10'd456, 10'd266, 11'd580, 11'd581, 11'd620, 11'd621,
                 10'd455, 10'd266, 1'b1);

        // Reserved tile on the first corner blocks like a wall
        special_addr = 580;
        special_code = 2'b11;
        run_move("rsvd_c0", 10'd456, 10'd266, 11'd580, 11'd581, 11'd620, 11'd621,
                 10'd455, 10'd266, 1'b1);

        // Wall on a middle corner
        special_addr = 620;
        special_code = 2'b01;
        run_move("wall_c2", 10'd456, 10'd266, 11'd580, 11'd581, 11'd620, 11'd621,
                 10'd455, 10'd266, 1'b1);
        special_addr = -1;

        // Proposal pulse while busy is dropped
        do_reset();
        prop_x = 10'd456;
        tick();
        tick();
        prop_x = 10'd457;
        tick();
        prop_x = 10'd456;
        tick();
        tick();
        tick();
        check_eq("drop_commit_x", 32'(commit_x), 32'd456);
        check_eq("drop_busy_done", 32'(busy), 32'd0);
        tick();
        tick();
        check_eq("drop_no_recheck", 32'(busy), 32'd0);
        check_eq("drop_commit_hold", 32'(commit_x), 32'd456);

        // Wrap-around tunnel across the left screen edge
        do_reset();
        run_move("to_origin", 10'd128, 10'd266, 11'd560, 11'd560, 11'd600, 11'd600,
                 10'd128, 10'd266, 1'b0);
        run_move("wrap", 10'd127, 10'd266, 11'd599, 11'd560, 11'd639, 11'd600,
                 10'd127, 10'd266, 1'b0);

        // Reset asserted mid-check during RD2
        special_addr = 661;
        special_code = 2'b01;
        prop_x = 10'd300;
        tick();
        tick();
        tick();
        check_eq("mid_busy_before", 32'(busy), 32'd1);
        #5;
        reset = 1'b1;
        #1;
        check_eq("mid_commit_x", 32'(commit_x), 32'd455);
        check_eq("mid_commit_y", 32'(commit_y), 32'd266);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_map_addr", 32'(map_addr), 32'd0);
        check_eq("mid_blocked", 32'(blocked), 32'd0);
        prop_x = 10'd455;
        prop_y = 10'd266;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("mid_post_blocked", 32'(blocked), 32'd0);
            check_eq("mid_post_busy", 32'(busy), 32'd0);
        end
        special_addr = -1;

        // Goal tile under one corner
        do_reset();
        special_addr = 581;
        special_code = 2'b10;
        run_move("goal", 10'd456, 10'd266, 11'd580, 11'd581, 11'd620, 11'd621,
                 10'd456, 10'd266, 1'b0);
`ifdef MEIKYUU_GOAL_DETECT_EN
        check_eq("goal_set", 32'(goal_reached), 32'd1);
        special_addr = -1;
        run_move("goal_hold", 10'd457, 10'd266, 11'd580, 11'd581, 11'd620, 11'd621,
                 10'd457, 10'd266, 1'b0);
        check_eq("goal_sticky", 32'(goal_reached), 32'd1);
        do_reset();
        check_eq("goal_reset", 32'(goal_reached), 32'd0);
`else
        check_eq("goal_tied_low", 32'(goal_reached), 32'd0);
        special_addr = -1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
